// File: rtl/rpipe_elastic.sv
// Elastic valid/ready register chain: DEPTH stages with bubble collapsing, global stall,
// synchronous flush and occupancy count. Define RPIPE_ELASTIC_SKID_EN to add a skid entry.

module rpipe_elastic_stage #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             clr,
   input  logic             ld,
   input  logic [WIDTH-1:0] d,
   input  logic             v,
   output logic [WIDTH-1:0] q,
   output logic             qv
);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q  <= '0;
         qv <= 1'b0;
      end else if (clr) begin
         q  <= '0;
         qv <= 1'b0;
      end else if (en && ld) begin
         q  <= d;
         qv <= v;
      end
   end
endmodule

module rpipe_elastic #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2,
   parameter int CW    = $clog2(DEPTH+2)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             clr,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [CW-1:0]    count
);
   logic [DEPTH-1:0]            vld_pipe;
   logic [DEPTH-1:0][WIDTH-1:0] dat_pipe;
   logic [DEPTH-1:0]            adv;
   logic [WIDTH-1:0]            src_d;
   logic                        src_v;
   logic [CW-1:0]               cnt;

`ifdef RPIPE_ELASTIC_SKID_EN
   logic             skid_v;
   logic [WIDTH-1:0] skid_d;

   // The skid only catches a word when stage 0 cannot take it; it drains before new input.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         skid_v <= 1'b0;
         skid_d <= '0;
      end else if (clr) begin
         skid_v <= 1'b0;
         skid_d <= '0;
      end else if (en) begin
         if (skid_v && adv[0]) begin
            skid_v <= 1'b0;
         end else if (!skid_v && in_valid && !adv[0]) begin
            skid_v <= 1'b1;
            skid_d <= in_data;
         end
      end
   end

   assign src_d    = skid_v ? skid_d : in_data;
   assign src_v    = skid_v | in_valid;
   assign in_ready = en & ~clr & ~skid_v;
`else
   assign src_d    = in_data;
   assign src_v    = in_valid;
   assign in_ready = en & ~clr & adv[0];
`endif

   for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      // A stage may advance iff some stage at or beyond it is empty, or the tail drains.
      assign adv[i] = out_ready | ~(&vld_pipe[DEPTH-1:i]);
      if (i == 0) begin : g_head
         rpipe_elastic_stage #(.WIDTH(WIDTH)) u_stage (
            .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .ld(adv[i]),
            .d(src_d), .v(src_v), .q(dat_pipe[i]), .qv(vld_pipe[i])
         );
      end else begin : g_body
         rpipe_elastic_stage #(.WIDTH(WIDTH)) u_stage (
            .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .ld(adv[i]),
            .d(dat_pipe[i-1]), .v(vld_pipe[i-1]), .q(dat_pipe[i]), .qv(vld_pipe[i])
         );
      end
   end

   always_comb begin
      cnt = '0;
      for (int i = 0; i < DEPTH; i++) cnt = cnt + CW'(vld_pipe[i]);
`ifdef RPIPE_ELASTIC_SKID_EN
      cnt = cnt + CW'(skid_v);
`endif
   end

   assign count     = cnt;
   assign out_valid = en & ~clr & vld_pipe[DEPTH-1];
   assign out_data  = dat_pipe[DEPTH-1];
endmodule

// File: tb/tb_rpipe_elastic.sv
// Randomised and directed bench for rpipe_elastic against a token/position queue model.
module tb_rpipe_elastic;
   localparam int W  = 32;
   localparam int D  = 2;
   localparam int CW = $clog2(D+2);
`ifdef RPIPE_ELASTIC_SKID_EN
   localparam int CAP  = D + 1;
   localparam bit SKID = 1'b1;
`else
   localparam int CAP  = D;
   localparam bit SKID = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          en = 1'b0, clr = 1'b0;
   logic          in_valid = 1'b0, out_ready = 1'b0;
   logic [W-1:0]  in_data = '0;
   logic          in_ready, out_valid;
   logic [W-1:0]  out_data;
   logic [CW-1:0] count;

   int checks = 0;
   int errors = 0;

   // Model: queue of words in order, each with its position (-1 = skid, D-1 = output stage).
   logic [W-1:0] mq[$];
   int           mp[$];

   rpipe_elastic #(.WIDTH(W), .DEPTH(D)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .count(count)
   );

   always #5 clk = ~clk;

   function automatic logic exp_in_ready();
      if (!en || clr) return 1'b0;
      if (SKID) begin
         foreach (mp[j]) if (mp[j] < 0) return 1'b0;
         return 1'b1;
      end
      return (mq.size() < D) || out_ready;
   endfunction

   function automatic logic head_last();
      return (mq.size() > 0) && (mp[0] == D-1);
   endfunction

   function automatic logic exp_out_valid();
      return en && !clr && head_last();
   endfunction

   task automatic model_edge();
      logic acc, iss;
      int   lim;
      if (!rst_n || clr) begin
         mq.delete();
         mp.delete();
         return;
      end
      if (!en) return;
      acc = in_valid && exp_in_ready();
      iss = exp_out_valid() && out_ready;
      if (iss) begin
         void'(mq.pop_front());
         void'(mp.pop_front());
      end
      if (acc) begin
         mq.push_back(in_data);
         mp.push_back(-1);
      end
      // Each word moves forward one place unless packed against the words ahead of it.
      foreach (mp[j]) begin
         lim = D - 1 - j;
         mp[j] = (mp[j] + 1 < lim) ? mp[j] + 1 : lim;
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic idle();
      en = 1'b1; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < CAP + 2; i++) cycle();
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if (out_valid !== 1'b0 || count !== '0 || out_data !== '0) begin
         errors++;
         $display("FAIL reset_state: out_valid=%b count=%0d out_data=%h, want 0/0/0", out_valid, count, out_data);
      end
      @(negedge clk);
      rst_n = 1'b1;
      en = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1 || count !== '0) begin
         errors++;
         $display("FAIL reset_release: in_ready=%b count=%0d, want 1/0", in_ready, count);
      end
      @(negedge clk);
   endtask

   task automatic test_streaming();
      int lat = 0;
      bit seen = 1'b0;
      en = 1'b1; clr = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
      for (int n = 0; n < 10; n++) begin
         in_data = W'(228 + n);
         #1;
         if (!seen && out_valid === 1'b1) begin
            seen = 1'b1;
            checks++;
            if (lat !== D || out_data !== W'(228)) begin
               errors++;
               $display("FAIL stream_latency: edges=%0d data=%0d, want %0d/228", lat, out_data, D);
            end
         end
         checks++;
         if (in_ready !== exp_in_ready() || out_valid !== exp_out_valid() || count !== CW'(mq.size())
             || (head_last() && out_data !== mq[0])) begin
            errors++;
            $display("FAIL stream_cyc%0d: rdy=%b vld=%b cnt=%0d data=%0d, want %b/%b/%0d/%0d", n, in_ready,
                     out_valid, count, out_data, exp_in_ready(), exp_out_valid(), mq.size(),
                     head_last() ? mq[0] : '0);
         end
         if (!seen) lat++;
         cycle();
      end
      checks++;
      if (count !== CW'(D)) begin
         errors++;
         $display("FAIL stream_steady_count: count=%0d, want %0d", count, D);
      end
      idle();
   endtask

   task automatic fill(input int base);
      int guard = 0;
      en = 1'b1; clr = 1'b0; out_ready = 1'b0; in_valid = 1'b1;
      in_data = W'(base);
      while (mq.size() < CAP && guard < 20) begin
         cycle();
         in_data = W'(base + mq.size());
         guard++;
      end
      in_valid = 1'b0;
      #1;
      checks++;
      if (guard >= 20 || count !== CW'(CAP)) begin
         errors++;
         $display("FAIL fill_%0d: count=%0d after %0d cycles, want %0d", base, count, guard, CAP);
      end
   endtask

   task automatic drain(input int base, input string tag);
      int got = 0;
      in_valid = 1'b0; out_ready = 1'b1; en = 1'b1;
      for (int c = 0; c < 4 * CAP + 4 && got < CAP; c++) begin
         #1;
         if (out_valid === 1'b1) begin
            checks++;
            if (out_data !== W'(base + got)) begin
               errors++;
               $display("FAIL %s_order%0d: data=%0d, want %0d", tag, got, out_data, base + got);
            end
            got++;
         end
         cycle();
      end
      checks++;
      if (got !== CAP || count !== '0) begin
         errors++;
         $display("FAIL %s_drain: words=%0d count=%0d, want %0d/0", tag, got, count, CAP);
      end
   endtask

   task automatic test_backpressure();
      fill(228);
      in_valid = 1'b1; in_data = W'(999);
      for (int c = 0; c < 3; c++) begin
         #1;
         checks++;
         if (in_ready !== 1'b0 || count !== CW'(CAP) || out_valid !== 1'b1 || out_data !== W'(228)) begin
            errors++;
            $display("FAIL backpressure_hold%0d: rdy=%b cnt=%0d vld=%b data=%0d, want 0/%0d/1/228", c,
                     in_ready, count, out_valid, out_data, CAP);
         end
         cycle();
      end
      drain(228, "backpressure");
   endtask

   task automatic test_stall();
      fill(300);
      en = 1'b0; in_valid = 1'b1; in_data = W'(777); out_ready = 1'b1;
      for (int c = 0; c < 5; c++) begin
         #1;
         checks++;
         if (in_ready !== 1'b0 || out_valid !== 1'b0 || count !== CW'(CAP) || out_data !== W'(300)) begin
            errors++;
            $display("FAIL stall_cyc%0d: rdy=%b vld=%b cnt=%0d data=%0d, want 0/0/%0d/300", c, in_ready,
                     out_valid, count, out_data, CAP);
         end
         cycle();
      end
      drain(300, "stall");
   endtask

   task automatic test_flush();
      fill(400);
      clr = 1'b1; en = 1'b1; in_valid = 1'b1; in_data = W'(555); out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL flush_during: rdy=%b vld=%b, want 0/0", in_ready, out_valid);
      end
      cycle();
      clr = 1'b0; in_valid = 1'b0;
      #1;
      checks++;
      if (count !== '0 || out_valid !== 1'b0 || out_data !== '0) begin
         errors++;
         $display("FAIL flush_after: cnt=%0d vld=%b data=%0d, want 0/0/0", count, out_valid, out_data);
      end
      for (int c = 0; c < D + 2; c++) cycle();
      #1;
      checks++;
      if (out_valid !== 1'b0 || count !== '0) begin
         errors++;
         $display("FAIL flush_no_accept: vld=%b cnt=%0d, want 0/0", out_valid, count);
      end
   endtask

   task automatic test_async_reset();
      fill(500);
      out_ready = 1'b1; en = 1'b1;
      #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || count !== '0 || out_data !== '0) begin
         errors++;
         $display("FAIL async_reset: vld=%b cnt=%0d data=%0d, want 0/0/0", out_valid, count, out_data);
      end
      mq.delete();
      mp.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_random();
      for (int c = 0; c < 600; c++) begin
         en        = ($urandom_range(0, 7) != 0);
         clr       = ($urandom_range(0, 39) == 0);
         in_valid  = ($urandom_range(0, 2) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         in_data   = $urandom;
         #1;
         checks++;
         if (in_ready !== exp_in_ready() || out_valid !== exp_out_valid() || count !== CW'(mq.size())
             || (head_last() && out_data !== mq[0])) begin
            errors++;
            $display("FAIL random_cyc%0d: rdy=%b vld=%b cnt=%0d data=%h, want %b/%b/%0d/%h", c, in_ready,
                     out_valid, count, out_data, exp_in_ready(), exp_out_valid(), mq.size(),
                     head_last() ? mq[0] : '0);
         end
         cycle();
      end
      clr = 1'b0;
      idle();
   endtask

   initial begin
      test_reset();
      test_streaming();
      test_backpressure();
      test_stall();
      test_flush();
      test_async_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/rpipe_elastic.md
Name: rpipe_elastic

Overview:
- Parametrised successor of the plain enable/clear pipeline register.
- A chain of DEPTH data stages, each with its own valid bit, and a valid/ready handshake on both ends.
- Adds per-stage bubble collapsing, global stall (en), synchronous flush (clr) and an occupancy count.
- Sits between RISC-V pipeline stages (e.g. fetch->decode queue, decode->execute) where back-pressure and hazard flushes must be honoured.

Parameters:
WIDTH, 32, payload width in bits (>=1)
DEPTH, 2, number of register stages (>=1)
CW, $clog2(DEPTH+2), width of occupancy count (derived, not overridden)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
en  in  1  global advance enable; 0 = freeze whole chain
clr  in  1  synchronous flush; priority over en and handshakes
in_valid  in  1  upstream has data
in_ready  out  1  block accepts data this cycle
in_data  in  WIDTH  upstream payload
out_valid  out  1  last stage holds data
out_ready  in  1  downstream accepts
out_data  out  WIDTH  payload of last stage
count  out  CW  number of valid entries held

Behaviour:
- Reset (rst_n=0, asynchronous): all stage data = 0, all valid bits = 0; out_valid=0, out_data=0, count=0.
- Reset is released on rst_n rising; the first edge after release behaves as normal operation.
- Transfers:
  - Input transfer occurs on an edge where in_valid & in_ready.
  - Output transfer occurs on an edge where out_valid & out_ready.
- Stage numbering: stage 0 is the input end, stage DEPTH-1 the output end.
- adv[DEPTH-1] = !v[DEPTH-1] | out_ready.
- adv[i] = !v[i] | adv[i+1]. The ready chain is combinational, so full throughput is possible with every stage occupied.
- On an edge with en=1 & clr=0:
  - stage i+1 loads stage i (data and valid) when adv[i+1]=1;
  - stage 0 loads in_data with valid=in_valid when adv[0]=1.
- Stages with adv=0 hold. Bubbles collapse: an empty stage is filled even when downstream is stalled.
- in_ready = en & !clr & adv[0].
- out_valid = en & !clr & v[DEPTH-1].
- out_data = data[DEPTH-1] regardless of en (stable while stalled).
- en=0: nothing changes, no transfer on either side, count holds.
- clr=1: at the edge, all valid bits become 0 and all data becomes 0. No input is accepted and no output is issued that cycle. count becomes 0 next cycle.
- Latency:
  - a word accepted at edge k appears on out_valid in cycle k+DEPTH when downstream is ready;
  - throughput is 1 word/cycle.
- Full: all v=1 and out_ready=0 gives in_ready=0, and data is held unchanged.
- Empty: out_valid=0. in_data is still loaded with valid=0 (no side effect).
- Simultaneous accept and issue when full: both occur and count is unchanged.
- count = sum of valid bits (plus skid entry when present), updated at the edge.
- Data integrity: no drop, no duplication, order preserved (FIFO semantics).
- DEPTH=1 degenerates to a single handshake register; this must be legal.

Optional Feature:
- Macro: RPIPE_ELASTIC_SKID_EN.
- Defined:
  - a one-entry skid register is added before stage 0;
  - in_ready = en & !clr & !skid_v, driven directly from a flop, which breaks the combinational ready path;
  - if a word is accepted while adv[0]=0, it goes to the skid register;
  - while skid_v=1, stage 0 loads from skid before new input;
  - capacity = DEPTH+1 and count ranges 0..DEPTH+1;
  - clr and reset also clear skid_v;
  - latency is unchanged when the skid is empty, and +1 when the word passes through the skid.
- Undefined: no skid register; in_ready is combinational as above; capacity = DEPTH.

Test Plan:
- Reset, DEPTH=2: hold rst_n=0 mid-cycle with data in flight -> out_valid=0, count=0 immediately (asynchronous, before the next edge).
- Streaming: in_valid=1, in_data=228,229,230…, out_ready=1, en=1 -> out_data=228 with out_valid in cycle k+2, then one word/cycle in order, count=2 steady.
- Back-pressure: out_ready=0 after 2 accepts -> in_ready=0, count=2, out_data=228 held. Raise out_ready -> 228, 229 drain without loss.
- Stall: en=0 for 5 cycles with chain full -> in_ready=0, out_valid=0, count and data unchanged. en=1 -> resumes with the same words.
- Flush: chain holding 2 words, clr=1 for one edge -> count=0, out_valid=0 next cycle. in_valid=1 during clr -> that word is not accepted.
- Skid (macro defined, DEPTH=2): full chain, out_ready=0, in_valid=1 -> one extra word accepted, count=3, then in_ready=0. Drain yields all 3 in order.
